// File: rtl/aes_pkg.sv
// Shared AES block-level types used by the core, the byte feeder and the block collector.
package aes_pkg;
  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

  // Collector phase: idle between blocks, assembling while a block is partially received.
  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_ASSEMBLING = 1'b1
  } col_state_t;
endpackage

// File: rtl/aes_block_collector_if.sv
// Byte stream in from the AES core and block stream out to the consumer.
interface aes_block_collector_if;
  import aes_pkg::*;

  // byte_valid qualifies byte_in every cycle it is high (no back-pressure on the byte side);
  // a block transfers on every rising edge where blk_valid & blk_ready, and blk_valid/blk_data
  // hold steady until that happens.
  logic [7:0] byte_in;
  logic       byte_valid;
  aes_block_t blk_data;
  logic       blk_valid;
  logic       blk_ready;

  modport master (
    output byte_in, byte_valid, blk_ready,
    input  blk_data, blk_valid
  );

  modport slave (
    input  byte_in, byte_valid, blk_ready,
    output blk_data, blk_valid
  );
endinterface

// File: rtl/aes_block_fifo.sv
// First-word-fall-through block FIFO; a push into a full FIFO is accepted only alongside a pop.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  aes_block_t               push_data,
  input  logic                     pop_ready,
  output aes_block_t               head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     accepted
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  aes_block_t        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;

  assign valid    = (level != '0);
  assign pop      = valid & pop_ready;
  assign accepted = push & ((level != FULL_LEVEL) | pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accepted) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accepted, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/aes_block_collector.sv
// Reassembles the AES core's 16-byte ciphertext runs into 128-bit blocks and queues them.
module aes_block_collector
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  aes_block_collector_if.slave   bus,
  output logic [3:0]             byte_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output col_state_t             state
);
  col_state_t  state_next;
  logic [119:0] asm_q;
  logic        take_byte;
  logic        asm_we;
  logic        push_req;
  logic        accepted;

  // clear always wins over a byte arriving in the same cycle.
  assign take_byte = bus.byte_valid & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (take_byte) state_next = ST_ASSEMBLING;
      ST_ASSEMBLING: if (clear || push_req) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    asm_we   = 1'b0;
    push_req = 1'b0;
    if (take_byte) begin
      asm_we   = (byte_cnt != 4'd15);
      push_req = (byte_cnt == 4'd15);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q    <= '0;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (asm_we) asm_q[8*byte_cnt +: 8] <= bus.byte_in;
      // The counter wraps 15 -> 0 whether the finished block was queued or dropped.
      if (clear)               byte_cnt <= '0;
      else if (bus.byte_valid) byte_cnt <= byte_cnt + 4'd1;
      if (clear)                     overflow <= 1'b0;
      else if (push_req & ~accepted) overflow <= 1'b1;
    end
  end

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data ({bus.byte_in, asm_q}),
    .pop_ready (bus.blk_ready),
    .head      (bus.blk_data),
    .valid     (bus.blk_valid),
    .level     (level),
    .accepted  (accepted)
  );
endmodule

// File: doc/aes_block_collector.md
# aes_block_collector

Downstream stage of the byte-serial AES encryption core. It consumes the core's ciphertext byte stream, which arrives as 16 consecutive bytes qualified by the core's `ready`, and reassembles each run into a 128-bit block. Completed blocks are held in a small FIFO and presented on a valid/ready handshake to the consumer, such as a bus slave or the next pipeline stage. A sticky flag reports any block lost because the FIFO was full.

## Interface
- `DEPTH`, 2: number of output FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `byte_in`  in  8  ciphertext byte; connect to the core's `state_out_byte`.
- `byte_valid`  in  1  byte qualifier; connect to the core's `ready`.
- `clear`  in  1  synchronous; discards the partial block and clears `overflow`.
- `blk_data`  out  128  head-of-FIFO block.
- `blk_valid`  out  1  FIFO non-empty.
- `blk_ready`  in  1  consumer accepts the head block when `blk_valid & blk_ready`.
- `byte_cnt`  out  4  bytes of the current partial block received (0–15).
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a completed block was dropped.

## Operation
- Byte ordering: the k-th accepted byte of a block (k = 0..15) lands in bits [8k+7:8k]. The first byte is the LSB byte, which matches the core's `j`-ascending emission order.
- Assembly register `asm` (120 bits) holds bytes 0–14. On each rising edge with `byte_valid=1` and `clear=0`:
  - byte_cnt < 15: `asm[8*byte_cnt +: 8] <= byte_in`; byte_cnt increments.
  - byte_cnt = 15: the block `{byte_in, asm}` is pushed; byte_cnt wraps to 0.
- Gaps are allowed. When `byte_valid=0`, byte_cnt and asm hold indefinitely; a block may span any number of idle cycles.
- Push/pop rules, with pop = `blk_valid & blk_ready`:
  - Push succeeds when level < DEPTH, or when level = DEPTH and a pop occurs in the same cycle.
  - Otherwise the block is dropped: `overflow <= 1`, FIFO contents are unchanged, and byte_cnt still wraps to 0.
  - Simultaneous push and pop leaves level unchanged and preserves order (FIFO, oldest first).
- `clear=1`: byte_cnt <= 0 and overflow <= 0. A `byte_valid` byte in the same cycle is discarded (clear wins). FIFO contents and a concurrent pop are unaffected.
- `blk_data` is don't-care when `blk_valid=0`. The bench must not check it in that state.
- Collector state machine, derived from byte_cnt and level:
  - IDLE (cnt=0) → ASSEMBLING on the first byte.
  - ASSEMBLING → IDLE on the 16th byte, with a push or an overflow.
  - ASSEMBLING → IDLE on clear.

## Timing
- Reset values: blk_valid=0, blk_data=0, byte_cnt=0, level=0, overflow=0. asm and FIFO storage reset to 0.
- Reset asserted mid-block or with the FIFO occupied: everything returns to reset values immediately (asynchronously). Buffered blocks are lost; overflow is not set.
- Latency: the 16th byte sampled at edge N gives blk_valid=1 and blk_data = the block after edge N. Head data is combinational from FIFO storage (first-word fall-through); there is no extra register stage.
- `overflow` rises after the edge that drops the block, and stays high until `clear` or reset.
- `blk_valid` stays high, with `blk_data` stable, until accepted. The consumer may hold `blk_ready` high continuously.
- Throughput: one block per 16 byte cycles sustained. The FIFO absorbs consumer stalls of up to DEPTH×16 cycles without loss.

## Structure
- Shared package `aes_pkg`: `AES_BLOCK_BITS=128`, `AES_BLOCK_BYTES=16`, and a `aes_block_t` 128-bit typedef, reused by the core and feeder.
- One sub-module, `aes_block_fifo`, holds the parameterised FWFT FIFO: push/pop, level, data. The top handles byte assembly, the counter and overflow.

## Test plan
- Reset, then 16 bytes 0x00..0x0F on consecutive cycles with `blk_ready=1`: one cycle after byte 0x0F, blk_valid=1 and blk_data=0x0F0E…0100. It pops in one cycle; level returns to 0 and overflow stays 0.
- The same 16 bytes with `byte_valid` toggling 1/0 (32 cycles): an identical block results, and byte_cnt steps 0→15→0.
- `blk_ready=0`, then three blocks streamed (0xA0+k, 0xB0+k, 0xC0+k): after the third, level=2 and overflow=1. Raising blk_ready pops block A (0xAF…A0), then B, then blk_valid=0.
- FIFO full with `blk_ready=1` exactly on the 16th byte of a third block: the push succeeds, level stays 2, and overflow stays 0.
- 7 bytes sent, then `clear` asserted together with an 8th byte: byte_cnt=0. The next 16 bytes 0x10..0x1F form a clean block 0x1F…10; overflow is cleared.
- Reset (`rst=0`) asynchronously mid-block (byte_cnt=9) with level=1: all outputs zero without a clock edge. After release, a new 16-byte block assembles correctly.
